dcache_responder: RTL and testbench



---
 rtl/dcache_pkg.sv | 24 ++
 rtl/dcache_line_array.sv | 78 +++++++
 rtl/dcache_responder.sv | 144 ++++++++++++++
 tb/tb_dcache_responder.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dcache_pkg.sv
// Shared types and constants for the direct-mapped write-back data cache.
package dcache_pkg;

    localparam int DEF_NUM_LINES = 8;
    localparam int LINE_WORDS    = 4;
    localparam int WORD_W        = 32;
    localparam int LINE_W        = 128;
    localparam int ADDR_W        = 30;
    localparam int LADDR_W       = 28;
    localparam int IDX_W         = $clog2(DEF_NUM_LINES);
    localparam int TAG_W         = LADDR_W - IDX_W;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WRITEBACK = 2'd1,
        ALLOCATE  = 2'd2
    } state_e;

    // Index width for a given line count.
    function automatic int idx_width(input int num_lines);
        return $clog2(num_lines);
    endfunction

endpackage

// File: rtl/dcache_line_array.sv
// Valid/dirty/tag/data storage for the cache: one combinational read port
// by index and one synchronous write port that either writes a single word
// (marking the line dirty) or fills a whole line (valid, clean).
module dcache_line_array
    import dcache_pkg::*;
#(
    parameter int NUM_LINES = 8,
    parameter int IDX_BITS  = 3,
    parameter int TAG_BITS  = 25
) (
    input  logic                clk,
    input  logic                rst_i,
    input  logic [IDX_BITS-1:0] rd_idx_i,
    output logic                rd_valid_o,
    output logic                rd_dirty_o,
    output logic [TAG_BITS-1:0] rd_tag_o,
    output logic [LINE_W-1:0]   rd_line_o,
    input  logic                wr_en_i,
    input  logic                wr_fill_i,
    input  logic [IDX_BITS-1:0] wr_idx_i,
    input  logic [1:0]          wr_off_i,
    input  logic [WORD_W-1:0]   wr_word_i,
    input  logic [TAG_BITS-1:0] wr_tag_i,
    input  logic [LINE_W-1:0]   wr_line_i
);

    logic [LINE_W-1:0]   data_q [NUM_LINES];
    logic [TAG_BITS-1:0] tag_q  [NUM_LINES];
    logic [NUM_LINES-1:0] valid_vec;
    logic [NUM_LINES-1:0] dirty_vec;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_LINES; gi++) begin : g_line
            logic valid_q;
            logic dirty_q;
            logic sel;

            assign sel = wr_en_i && (wr_idx_i == IDX_BITS'(gi));

            // Per-line status bits: cleared by reset, set by fill or word write.
            always_ff @(posedge clk) begin
                if (rst_i) begin
                    valid_q <= 1'b0;
                    dirty_q <= 1'b0;
                end else if (sel) begin
                    if (wr_fill_i) begin
                        valid_q <= 1'b1;
                        dirty_q <= 1'b0;
                    end else begin
                        dirty_q <= 1'b1;
                    end
                end
            end

            assign valid_vec[gi] = valid_q;
            assign dirty_vec[gi] = dirty_q;
        end
    endgenerate

    // Tag and data storage are not reset; a cleared valid bit hides them.
    always_ff @(posedge clk) begin
        if (wr_en_i) begin
            if (wr_fill_i) begin
                data_q[wr_idx_i] <= wr_line_i;
                tag_q[wr_idx_i]  <= wr_tag_i;
            end else begin
                data_q[wr_idx_i][{wr_off_i, 5'd0} +: WORD_W] <= wr_word_i;
            end
        end
    end

    assign rd_valid_o = valid_vec[rd_idx_i];
    assign rd_dirty_o = dirty_vec[rd_idx_i];
    assign rd_tag_o   = tag_q[rd_idx_i];
    assign rd_line_o  = data_q[rd_idx_i];

endmodule

// File: rtl/dcache_responder.sv
// Direct-mapped, write-back, write-allocate data cache facing the core's
// MEM stage. Hits complete with zero stall; a miss writes back a dirty
// victim, refills the line over the 128-bit port, then hits on replay.
module dcache_responder
    import dcache_pkg::*;
#(
    parameter int NUM_LINES      = DEF_NUM_LINES,
    parameter int WORDS_PER_LINE = LINE_WORDS
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                proc_read,
    input  logic                proc_write,
    input  logic [ADDR_W-1:0]   proc_addr,
    input  logic [WORD_W-1:0]   proc_wdata,
    output logic [WORD_W-1:0]   proc_rdata,
    output logic                proc_stall,
    output logic                mem_read,
    output logic                mem_write,
    output logic [LADDR_W-1:0]  mem_addr,
    output logic [LINE_W-1:0]   mem_wdata,
    input  logic [LINE_W-1:0]   mem_rdata,
    input  logic                mem_ready
);

    localparam int IDX_BITS = idx_width(NUM_LINES);
    localparam int TAG_BITS = LADDR_W - IDX_BITS;

    generate
        if (NUM_LINES < 2 || (NUM_LINES & (NUM_LINES - 1)) != 0 || WORDS_PER_LINE != 4) begin : g_bad_param
            $error("dcache_responder: NUM_LINES must be a power of 2 >= 2 and WORDS_PER_LINE must be 4");
        end
    endgenerate

    state_e              state_q;
    logic                mem_read_q;
    logic                mem_write_q;
    logic [IDX_BITS-1:0] miss_idx_q;
    logic [TAG_BITS-1:0] miss_tag_q;

    logic                req;
    logic [1:0]          addr_off;
    logic [IDX_BITS-1:0] addr_idx;
    logic [TAG_BITS-1:0] addr_tag;
    logic [IDX_BITS-1:0] look_idx;
    logic                hit;

    logic                rd_valid;
    logic                rd_dirty;
    logic [TAG_BITS-1:0] rd_tag;
    logic [LINE_W-1:0]   rd_line;

    logic                arr_wr_en;
    logic                arr_wr_fill;

    assign req      = proc_read | proc_write;
    assign addr_off = proc_addr[1:0];
    assign addr_idx = proc_addr[IDX_BITS+1:2];
    assign addr_tag = proc_addr[ADDR_W-1:IDX_BITS+2];

    // While a miss is in flight the array is addressed by the latched index,
    // so the write-back and fill target the line that missed.
    assign look_idx = (state_q == IDLE) ? addr_idx : miss_idx_q;

    assign hit        = rd_valid & (rd_tag == addr_tag);
    assign proc_stall = (req & ~hit) | (state_q != IDLE);
    assign proc_rdata = rd_line[{addr_off, 5'd0} +: WORD_W];

    assign mem_read  = mem_read_q;
    assign mem_write = mem_write_q;
    assign mem_addr  = (state_q == WRITEBACK) ? {rd_tag, miss_idx_q} : {miss_tag_q, miss_idx_q};
    assign mem_wdata = rd_line;

    // Word write on an IDLE write hit (write wins over read); line fill on
    // the mem_ready edge of ALLOCATE.
    assign arr_wr_fill = (state_q == ALLOCATE);
    assign arr_wr_en   = ~rst & (((state_q == IDLE) & proc_write & hit) |
                                 ((state_q == ALLOCATE) & mem_ready));

    dcache_line_array #(
        .NUM_LINES (NUM_LINES),
        .IDX_BITS  (IDX_BITS),
        .TAG_BITS  (TAG_BITS)
    ) u_lines (
        .clk        (clk),
        .rst_i      (rst),
        .rd_idx_i   (look_idx),
        .rd_valid_o (rd_valid),
        .rd_dirty_o (rd_dirty),
        .rd_tag_o   (rd_tag),
        .rd_line_o  (rd_line),
        .wr_en_i    (arr_wr_en),
        .wr_fill_i  (arr_wr_fill),
        .wr_idx_i   (look_idx),
        .wr_off_i   (addr_off),
        .wr_word_i  (proc_wdata),
        .wr_tag_i   (miss_tag_q),
        .wr_line_i  (mem_rdata)
    );

    // Miss FSM with registered memory strobes; latches the missing line on entry.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            mem_read_q  <= 1'b0;
            mem_write_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (req & ~hit) begin
                        miss_idx_q <= addr_idx;
                        miss_tag_q <= addr_tag;
                        if (rd_valid & rd_dirty) begin
                            state_q     <= WRITEBACK;
                            mem_write_q <= 1'b1;
                        end else begin
                            state_q    <= ALLOCATE;
                            mem_read_q <= 1'b1;
                        end
                    end
                end
                WRITEBACK: begin
                    if (mem_ready) begin
                        state_q     <= ALLOCATE;
                        mem_write_q <= 1'b0;
                        mem_read_q  <= 1'b1;
                    end
                end
                ALLOCATE: begin
                    if (mem_ready) begin
                        state_q    <= IDLE;
                        mem_read_q <= 1'b0;
                    end
                end
                default: begin
                    state_q     <= IDLE;
                    mem_read_q  <= 1'b0;
                    mem_write_q <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dcache_responder.sv
// Self-checking bench for dcache_responder: a cache/memory reference model
// predicts read data (pushed to a scoreboard queue at drive time), hit/miss
// and write-back behaviour; a vector table plus hand-written corner cases.
module tb_dcache_responder;

    logic          clk = 1'b0;
    logic          rst;
    logic          proc_read;
    logic          proc_write;
    logic [29:0]   proc_addr;
    logic [31:0]   proc_wdata;
    logic [31:0]   proc_rdata;
    logic          proc_stall;
    logic          mem_read;
    logic          mem_write;
    logic [27:0]   mem_addr;
    logic [127:0]  mem_wdata;
    logic [127:0]  mem_rdata;
    logic          mem_ready;

    always #5 clk = ~clk;

    dcache_responder #(.NUM_LINES(8), .WORDS_PER_LINE(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .proc_read  (proc_read),
        .proc_write (proc_write),
        .proc_addr  (proc_addr),
        .proc_wdata (proc_wdata),
        .proc_rdata (proc_rdata),
        .proc_stall (proc_stall),
        .mem_read   (mem_read),
        .mem_write  (mem_write),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata),
        .mem_ready  (mem_ready)
    );

    int checks = 0;
    int errors = 0;

    logic [31:0]  exp_q [$];
    bit           mv [8];
    bit           md [8];
    logic [24:0]  mt [8];
    logic [127:0] cdata [8];
    logic [127:0] mem_model [logic [27:0]];

    typedef struct {
        string       name;
        bit          rd;
        bit          wr;
        logic [29:0] addr;
        logic [31:0] wdata;
        bit          exp_miss;
        bit          exp_wb;
        int          wait_c;
    } vec_t;

    vec_t vecs [13];

    function automatic logic [127:0] init_line(input logic [27:0] la);
        logic [127:0] l;
        for (int w = 0; w < 4; w++)
            l[w*32 +: 32] = 32'hA000_0000 | {4'h0, la[23:0], 4'(w)};
        return l;
    endfunction

    function automatic logic [127:0] get_line(input logic [27:0] la);
        if (mem_model.exists(la))
            return mem_model[la];
        return init_line(la);
    endfunction

    task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 8; i++) begin
            mv[i] = 1'b0;
            md[i] = 1'b0;
        end
    endtask

    // One core access, serviced to completion; starts and ends just after a posedge.
    task automatic do_access(input string nm, input bit rd, input bit wr,
                             input logic [29:0] addr, input logic [31:0] wdata,
                             input bit exp_miss, input bit exp_wb, input int wait_c);
        logic [2:0]   idx;
        logic [24:0]  tg;
        logic [1:0]   off;
        logic [27:0]  la;
        logic [127:0] exp_line;
        logic [127:0] held_wdata;
        logic [27:0]  held_addr;
        bit           saw_wb, saw_alloc, wb_done, done;
        int           wb_cnt, al_cnt, fill_cyc;

        idx = addr[4:2];
        tg  = addr[29:5];
        off = addr[1:0];
        la  = addr[29:2];
        if (!wr) begin
            if (mv[idx] && mt[idx] == tg) exp_line = cdata[idx];
            else                          exp_line = get_line(la);
            exp_q.push_back(exp_line[off*32 +: 32]);
        end
        proc_read  = rd;
        proc_write = wr;
        proc_addr  = addr;
        proc_wdata = wdata;
        @(negedge clk);
        check({nm, " miss"}, 128'(proc_stall), 128'(exp_miss));
        done = 0; saw_wb = 0; saw_alloc = 0; wb_done = 0;
        wb_cnt = 0; al_cnt = 0; fill_cyc = 0;
        held_addr = '0; held_wdata = '0;
        for (int cyc = 0; cyc < 200 && !done; cyc++) begin
            if (cyc > 0) begin
                @(posedge clk); #1;
                mem_ready = 1'b0;
                @(negedge clk);
            end
            if (!proc_stall) begin
                check({nm, " miss served"}, 128'(saw_alloc), 128'(exp_miss));
                if (saw_alloc)
                    check({nm, " fill-to-hit"}, 128'(cyc - fill_cyc), 128'(1));
                check({nm, " idle mem strobes"}, 128'({mem_read, mem_write}), 128'(0));
                if (wr) begin
                    cdata[idx][off*32 +: 32] = wdata;
                    md[idx] = 1'b1;
                end else if (exp_q.size() == 0) begin
                    check({nm, " scoreboard empty"}, 128'(1), 128'(0));
                end else begin
                    check({nm, " rdata"}, 128'(proc_rdata), 128'(exp_q.pop_front()));
                end
                done = 1;
            end else if (cyc == 0) begin
                check({nm, " first stall strobes"}, 128'({mem_read, mem_write}), 128'(0));
            end else begin
                check({nm, " strobes exclusive"}, 128'(mem_read & mem_write), 128'(0));
                if (mem_write) begin
                    if (!saw_wb) begin
                        saw_wb     = 1;
                        held_addr  = mem_addr;
                        held_wdata = mem_wdata;
                        check({nm, " wb addr"}, 128'(mem_addr), 128'({mt[idx], idx}));
                        check({nm, " wb data"}, mem_wdata, cdata[idx]);
                    end else begin
                        check({nm, " wb addr stable"}, 128'(mem_addr), 128'(held_addr));
                        check({nm, " wb data stable"}, mem_wdata, held_wdata);
                    end
                    if (wb_cnt == wait_c) begin
                        mem_ready = 1'b1;
                        mem_model[{mt[idx], idx}] = cdata[idx];
                        wb_done = 1;
                    end
                    wb_cnt++;
                end else if (mem_read) begin
                    if (!saw_alloc) begin
                        saw_alloc = 1;
                        check({nm, " refill addr"}, 128'(mem_addr), 128'(la));
                        check({nm, " wb before refill"}, 128'(wb_done), 128'(exp_wb));
                    end
                    if (al_cnt == wait_c) begin
                        mem_rdata  = get_line(la);
                        mem_ready  = 1'b1;
                        cdata[idx] = get_line(la);
                        mt[idx]    = tg;
                        mv[idx]    = 1'b1;
                        md[idx]    = 1'b0;
                        fill_cyc   = cyc;
                    end
                    al_cnt++;
                end else begin
                    check({nm, " stalled without memory op"}, 128'(1), 128'(0));
                end
            end
        end
        if (!done) check({nm, " timeout"}, 128'(0), 128'(1));
        check({nm, " writeback seen"}, 128'(saw_wb), 128'(exp_wb));
        $display("TXN %s addr=%0h rd=%0b wr=%0b wb=%0b refill=%0b", nm, addr, rd, wr, saw_wb, saw_alloc);
        @(posedge clk); #1;
        proc_read  = 1'b0;
        proc_write = 1'b0;
        mem_ready  = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [127:0] tmp;
        bit           seen;

        vecs[0]  = '{"rd 0x10 rehit",        1'b1, 1'b0, 30'h10, 32'h0,        1'b0, 1'b0, 0};
        vecs[1]  = '{"wr 0x10 hit",          1'b0, 1'b1, 30'h10, 32'h12345678, 1'b0, 1'b0, 0};
        vecs[2]  = '{"rd 0x30 dirty victim", 1'b1, 1'b0, 30'h30, 32'h0,        1'b1, 1'b1, 1};
        vecs[3]  = '{"wr 0x4B clean miss",   1'b0, 1'b1, 30'h4B, 32'hCAFEF00D, 1'b1, 1'b0, 2};
        vecs[4]  = '{"rd 0x4B new word",     1'b1, 1'b0, 30'h4B, 32'h0,        1'b0, 1'b0, 0};
        vecs[5]  = '{"rd 0x48 refill word",  1'b1, 1'b0, 30'h48, 32'h0,        1'b0, 1'b0, 0};
        vecs[6]  = '{"rd 0x49 refill word",  1'b1, 1'b0, 30'h49, 32'h0,        1'b0, 1'b0, 0};
        vecs[7]  = '{"rd 0x10 from memory",  1'b1, 1'b0, 30'h10, 32'h0,        1'b1, 1'b0, 0};
        vecs[8]  = '{"rw 0x11 write wins",   1'b1, 1'b1, 30'h11, 32'h55AA55AA, 1'b0, 1'b0, 0};
        vecs[9]  = '{"rd 0x11",              1'b1, 1'b0, 30'h11, 32'h0,        1'b0, 1'b0, 0};
        vecs[10] = '{"wr 0x6B dirty miss",   1'b0, 1'b1, 30'h6B, 32'h0BADF00D, 1'b1, 1'b1, 3};
        vecs[11] = '{"rd 0x4B after evict",  1'b1, 1'b0, 30'h4B, 32'h0,        1'b1, 1'b1, 0};
        vecs[12] = '{"rd 0x31 wb hold 20",   1'b1, 1'b0, 30'h31, 32'h0,        1'b1, 1'b1, 20};

        tmp = init_line(28'h4);
        tmp[31:0] = 32'hDEADBEEF;
        mem_model[28'h4] = tmp;

        rst        = 1'b1;
        proc_read  = 1'b1;
        proc_write = 1'b0;
        proc_addr  = 30'h10;
        proc_wdata = 32'h0;
        mem_ready  = 1'b0;
        mem_rdata  = '0;
        model_reset();

        // Reset: strobes low, stall follows the request.
        @(posedge clk); #1;
        @(negedge clk);
        check("reset stall with req", 128'(proc_stall), 128'(1));
        check("reset mem_read", 128'(mem_read), 128'(0));
        check("reset mem_write", 128'(mem_write), 128'(0));
        proc_read = 1'b0;
        #1;
        check("reset stall no req", 128'(proc_stall), 128'(0));
        @(posedge clk); #1;
        rst = 1'b0;

        do_access("rd 0x10 cold", 1'b1, 1'b0, 30'h10, 32'h0, 1'b1, 1'b0, 2);

        for (int i = 0; i < 13; i++)
            do_access(vecs[i].name, vecs[i].rd, vecs[i].wr, vecs[i].addr, vecs[i].wdata,
                      vecs[i].exp_miss, vecs[i].exp_wb, vecs[i].wait_c);

        // mem_ready while idle must be ignored.
        mem_rdata = '1;
        mem_ready = 1'b1;
        @(negedge clk);
        check("idle ready stall", 128'(proc_stall), 128'(0));
        @(posedge clk); #1;
        mem_ready = 1'b0;
        @(negedge clk);
        check("idle ready strobes", 128'({mem_read, mem_write}), 128'(0));
        @(posedge clk); #1;
        $display("TXN idle mem_ready pulse");
        do_access("rd 0x31 still hits", 1'b1, 1'b0, 30'h31, 32'h0, 1'b0, 1'b0, 0);

        // Reset while ALLOCATE waits on memory.
        proc_read = 1'b1;
        proc_addr = 30'h04;
        seen = 0;
        for (int i = 0; i < 10 && !seen; i++) begin
            @(negedge clk);
            if (mem_read) seen = 1;
            else begin
                @(posedge clk); #1;
            end
        end
        check("alloc reached before reset", 128'(seen), 128'(1));
        rst = 1'b1;
        @(posedge clk); #1;
        rst       = 1'b0;
        proc_read = 1'b0;
        @(negedge clk);
        check("mid-miss reset mem_read", 128'(mem_read), 128'(0));
        check("mid-miss reset mem_write", 128'(mem_write), 128'(0));
        check("mid-miss reset idle", 128'(proc_stall), 128'(0));
        model_reset();
        @(posedge clk); #1;
        $display("TXN reset during refill");
        do_access("rd 0x31 misses after reset", 1'b1, 1'b0, 30'h31, 32'h0, 1'b1, 1'b0, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
